// File: rtl/ped_signal_ctrl_if.sv
// Signal bundle between the pedestrian signal controller and its environment:
// light/tick/button inputs in, lamp and status outputs back.
interface ped_signal_ctrl_if;
   logic       enable;
   logic       red;
   logic       yellow;
   logic       green;
   logic       button;
   logic       walk;
   logic       dont_walk;
   logic [5:0] countdown;
   logic       request_pending;
   logic       fault;

   modport master (
      output enable, red, yellow, green, button,
      input  walk, dont_walk, countdown, request_pending, fault
   );

   modport slave (
      input  enable, red, yellow, green, button,
      output walk, dont_walk, countdown, request_pending, fault
   );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / flashing DON'T WALK sequencer slaved to the vehicle light FSM.
// Grants WALK only on a vehicle red rising edge and aborts safely if red is lost.
//
// state | meaning
// IDLE  | steady DON'T WALK, waiting for a request plus a red rising edge
// WALK  | WALK lamp on, counting down WALK_TICKS enable ticks
// FLASH | DON'T WALK flashing, counting down FLASH_TICKS enable ticks
module ped_signal_ctrl #(
   parameter int unsigned WALK_TICKS  = 16,
   parameter int unsigned FLASH_TICKS = 8
) (
   input logic              clk,
   input logic              reset,
   ped_signal_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WALK  = 2'd1,
      S_FLASH = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;
   logic       req_q, req_d;
   logic       red_q, red_d;
   logic       fault_q, fault_d;
   logic       walk_q, walk_d;
   logic       dont_walk_q, dont_walk_d;

   logic       legal;
   logic       red_rise;

   // Exactly one of three: odd parity rules out 0 and 2, the AND rules out 3.
   assign legal    = (bus.red ^ bus.yellow ^ bus.green) & ~(bus.red & bus.yellow & bus.green);
   assign red_rise = bus.red & ~red_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      req_d   = req_q | bus.button;
      red_d   = bus.red;
      fault_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!legal) begin
               fault_d = 1'b1;
            end else if (red_rise && req_q) begin
               state_d = S_WALK;
               cnt_d   = 6'(WALK_TICKS);
               req_d   = bus.button;
            end
         end
         S_WALK: begin
            if (!legal || !bus.red) begin
               state_d = S_IDLE;
               cnt_d   = 6'd0;
               fault_d = 1'b1;
            end else if (bus.enable) begin
               if (cnt_q == 6'd1) begin
                  state_d = S_FLASH;
                  cnt_d   = 6'(FLASH_TICKS);
                  phase_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
         end
         S_FLASH: begin
            if (!legal || !bus.red) begin
               state_d = S_IDLE;
               cnt_d   = 6'd0;
               fault_d = 1'b1;
            end else if (bus.enable) begin
               if (cnt_q == 6'd1) begin
                  state_d = S_IDLE;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d   = cnt_q - 6'd1;
                  phase_d = ~phase_q;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase

      // Lamps are decoded from the next state so they leave straight from flops.
      walk_d      = (state_d == S_WALK);
      dont_walk_d = (state_d == S_IDLE) | ((state_d == S_FLASH) & phase_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 6'd0;
         phase_q     <= 1'b0;
         req_q       <= 1'b0;
         red_q       <= 1'b1;
         fault_q     <= 1'b0;
         walk_q      <= 1'b0;
         dont_walk_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         req_q       <= req_d;
         red_q       <= red_d;
         fault_q     <= fault_d;
         walk_q      <= walk_d;
         dont_walk_q <= dont_walk_d;
      end
   end

   assign bus.walk            = walk_q;
   assign bus.dont_walk       = dont_walk_q;
   assign bus.countdown       = cnt_q;
   assign bus.request_pending = req_q;
   assign bus.fault           = fault_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl: default-parameter instance for the main
// scenarios plus a short-timer instance for enable gating.
module tb_ped_signal_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   ped_signal_ctrl_if bus_a ();
   ped_signal_ctrl_if bus_b ();

   ped_signal_ctrl u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   ped_signal_ctrl #(.WALK_TICKS(2), .FLASH_TICKS(1)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic light_a(input logic r, input logic y, input logic g);
      bus_a.red    = r;
      bus_a.yellow = y;
      bus_a.green  = g;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++; if (bus_a.walk !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b expected 0", bus_a.walk); end
      checks++; if (bus_a.dont_walk !== 1'b1) begin errors++; $display("FAIL reset_dont_walk: got %b expected 1", bus_a.dont_walk); end
      checks++; if (bus_a.countdown !== 6'd0) begin errors++; $display("FAIL reset_countdown: got %0d expected 0", bus_a.countdown); end
      checks++; if (bus_a.request_pending !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus_a.request_pending); end
      checks++; if (bus_a.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus_a.fault); end
   endtask

   task automatic test_nominal();
      light_a(1'b0, 1'b0, 1'b1);
      bus_a.enable = 1'b1;
      bus_a.button = 1'b1;
      step();
      bus_a.button = 1'b0;
      checks++; if (bus_a.request_pending !== 1'b1) begin errors++; $display("FAIL nom_req: got %b expected 1", bus_a.request_pending); end
      step();
      light_a(1'b0, 1'b1, 1'b0);
      step();
      step();
      light_a(1'b1, 1'b0, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b1) begin errors++; $display("FAIL nom_walk_entry: got %b expected 1", bus_a.walk); end
      checks++; if (bus_a.countdown !== 6'd16) begin errors++; $display("FAIL nom_walk_count: got %0d expected 16", bus_a.countdown); end
      checks++; if (bus_a.request_pending !== 1'b0) begin errors++; $display("FAIL nom_req_clear: got %b expected 0", bus_a.request_pending); end
      checks++; if (bus_a.dont_walk !== 1'b0) begin errors++; $display("FAIL nom_walk_dw: got %b expected 0", bus_a.dont_walk); end
      for (int k = 1; k <= 15; k++) begin
         step();
         checks++; if (bus_a.walk !== 1'b1 || bus_a.countdown !== 6'(16 - k)) begin
            errors++; $display("FAIL nom_walk_tick%0d: got walk=%b cnt=%0d expected walk=1 cnt=%0d", k, bus_a.walk, bus_a.countdown, 16 - k);
         end
      end
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.countdown !== 6'd8 || bus_a.dont_walk !== 1'b1) begin
         errors++; $display("FAIL nom_flash_entry: got walk=%b cnt=%0d dw=%b expected walk=0 cnt=8 dw=1", bus_a.walk, bus_a.countdown, bus_a.dont_walk);
      end
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++; if (bus_a.countdown !== 6'(8 - k) || bus_a.dont_walk !== ((k % 2) == 0)) begin
            errors++; $display("FAIL nom_flash_tick%0d: got cnt=%0d dw=%b expected cnt=%0d dw=%b", k, bus_a.countdown, bus_a.dont_walk, 8 - k, (k % 2) == 0);
         end
      end
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.countdown !== 6'd0 || bus_a.dont_walk !== 1'b1 || bus_a.fault !== 1'b0) begin
         errors++; $display("FAIL nom_idle: got walk=%b cnt=%0d dw=%b fault=%b expected 0/0/1/0", bus_a.walk, bus_a.countdown, bus_a.dont_walk, bus_a.fault);
      end
      light_a(1'b0, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_mid_red();
      light_a(1'b1, 1'b0, 1'b0);
      step();
      step();
      bus_a.button = 1'b1;
      step();
      bus_a.button = 1'b0;
      checks++; if (bus_a.request_pending !== 1'b1 || bus_a.walk !== 1'b0) begin
         errors++; $display("FAIL midred_press: got req=%b walk=%b expected req=1 walk=0", bus_a.request_pending, bus_a.walk);
      end
      repeat (5) step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.request_pending !== 1'b1) begin
         errors++; $display("FAIL midred_wait: got walk=%b req=%b expected walk=0 req=1", bus_a.walk, bus_a.request_pending);
      end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      light_a(1'b0, 1'b1, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b0) begin errors++; $display("FAIL midred_prerise: got %b expected 0", bus_a.walk); end
      light_a(1'b1, 1'b0, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b1 || bus_a.countdown !== 6'd16) begin
         errors++; $display("FAIL midred_next_red: got walk=%b cnt=%0d expected walk=1 cnt=16", bus_a.walk, bus_a.countdown);
      end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      step();
   endtask

   task automatic test_abort();
      light_a(1'b0, 1'b0, 1'b1);
      bus_a.button = 1'b1;
      step();
      bus_a.button = 1'b0;
      light_a(1'b1, 1'b0, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b1) begin errors++; $display("FAIL abort_entry: got %b expected 1", bus_a.walk); end
      repeat (4) step();
      checks++; if (bus_a.countdown !== 6'd12) begin errors++; $display("FAIL abort_pre_cnt: got %0d expected 12", bus_a.countdown); end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.dont_walk !== 1'b1 || bus_a.countdown !== 6'd0 || bus_a.fault !== 1'b1) begin
         errors++; $display("FAIL abort_safe: got walk=%b dw=%b cnt=%0d fault=%b expected 0/1/0/1", bus_a.walk, bus_a.dont_walk, bus_a.countdown, bus_a.fault);
      end
      checks++; if (bus_a.request_pending !== 1'b0) begin errors++; $display("FAIL abort_req: got %b expected 0", bus_a.request_pending); end
      step();
      checks++; if (bus_a.fault !== 1'b0 || bus_a.walk !== 1'b0) begin
         errors++; $display("FAIL abort_fault_end: got fault=%b walk=%b expected 0/0", bus_a.fault, bus_a.walk);
      end
   endtask

   task automatic test_illegal();
      light_a(1'b0, 1'b0, 1'b1);
      step();
      light_a(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus_a.fault !== 1'b1 || bus_a.walk !== 1'b0) begin
            errors++; $display("FAIL illegal_fault%0d: got fault=%b walk=%b expected 1/0", k, bus_a.fault, bus_a.walk);
         end
      end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      checks++; if (bus_a.fault !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b expected 0", bus_a.fault); end
      bus_a.button = 1'b1;
      step();
      bus_a.button = 1'b0;
      light_a(1'b1, 1'b1, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.fault !== 1'b1) begin
         errors++; $display("FAIL illegal_rise: got walk=%b fault=%b expected 0/1", bus_a.walk, bus_a.fault);
      end
      light_a(1'b1, 1'b0, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.fault !== 1'b0 || bus_a.request_pending !== 1'b1) begin
         errors++; $display("FAIL illegal_no_late_walk: got walk=%b fault=%b req=%b expected 0/0/1", bus_a.walk, bus_a.fault, bus_a.request_pending);
      end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      light_a(1'b1, 1'b0, 1'b0);
      step();
      checks++; if (bus_a.walk !== 1'b1) begin errors++; $display("FAIL illegal_recover_walk: got %b expected 1", bus_a.walk); end
      light_a(1'b0, 1'b0, 1'b1);
      step();
      step();
   endtask

   task automatic test_enable_gating();
      bus_b.red    = 1'b0;
      bus_b.yellow = 1'b0;
      bus_b.green  = 1'b1;
      bus_b.enable = 1'b0;
      bus_b.button = 1'b1;
      step();
      bus_b.button = 1'b0;
      bus_b.red    = 1'b1;
      bus_b.green  = 1'b0;
      step();
      checks++; if (bus_b.walk !== 1'b1 || bus_b.countdown !== 6'd2) begin
         errors++; $display("FAIL gate_entry: got walk=%b cnt=%0d expected 1/2", bus_b.walk, bus_b.countdown);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus_b.walk !== 1'b1 || bus_b.countdown !== 6'd2) begin
            errors++; $display("FAIL gate_hold_a%0d: got walk=%b cnt=%0d expected 1/2", k, bus_b.walk, bus_b.countdown);
         end
      end
      bus_b.enable = 1'b1;
      step();
      bus_b.enable = 1'b0;
      checks++; if (bus_b.walk !== 1'b1 || bus_b.countdown !== 6'd1) begin
         errors++; $display("FAIL gate_tick1: got walk=%b cnt=%0d expected 1/1", bus_b.walk, bus_b.countdown);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus_b.walk !== 1'b1 || bus_b.countdown !== 6'd1) begin
            errors++; $display("FAIL gate_hold_b%0d: got walk=%b cnt=%0d expected 1/1", k, bus_b.walk, bus_b.countdown);
         end
      end
      bus_b.enable = 1'b1;
      step();
      bus_b.enable = 1'b0;
      checks++; if (bus_b.walk !== 1'b0 || bus_b.countdown !== 6'd1 || bus_b.dont_walk !== 1'b1) begin
         errors++; $display("FAIL gate_flash: got walk=%b cnt=%0d dw=%b expected 0/1/1", bus_b.walk, bus_b.countdown, bus_b.dont_walk);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus_b.countdown !== 6'd1 || bus_b.dont_walk !== 1'b1) begin
            errors++; $display("FAIL gate_hold_c%0d: got cnt=%0d dw=%b expected 1/1", k, bus_b.countdown, bus_b.dont_walk);
         end
      end
      bus_b.enable = 1'b1;
      step();
      bus_b.enable = 1'b0;
      checks++; if (bus_b.walk !== 1'b0 || bus_b.countdown !== 6'd0 || bus_b.dont_walk !== 1'b1 || bus_b.fault !== 1'b0) begin
         errors++; $display("FAIL gate_idle: got walk=%b cnt=%0d dw=%b fault=%b expected 0/0/1/0", bus_b.walk, bus_b.countdown, bus_b.dont_walk, bus_b.fault);
      end
      bus_b.red   = 1'b0;
      bus_b.green = 1'b1;
   endtask

   task automatic test_reset_mid_flash();
      light_a(1'b0, 1'b0, 1'b1);
      bus_a.button = 1'b1;
      step();
      bus_a.button = 1'b0;
      light_a(1'b1, 1'b0, 1'b0);
      step();
      repeat (16) step();
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.countdown !== 6'd7 || bus_a.dont_walk !== 1'b0) begin
         errors++; $display("FAIL rst_pre_flash: got walk=%b cnt=%0d dw=%b expected 0/7/0", bus_a.walk, bus_a.countdown, bus_a.dont_walk);
      end
      bus_a.button = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus_a.button = 1'b0;
      checks++; if (bus_a.walk !== 1'b0 || bus_a.dont_walk !== 1'b1 || bus_a.countdown !== 6'd0 || bus_a.request_pending !== 1'b0 || bus_a.fault !== 1'b0) begin
         errors++; $display("FAIL rst_mid_flash: got walk=%b dw=%b cnt=%0d req=%b fault=%b expected 0/1/0/0/0",
                            bus_a.walk, bus_a.dont_walk, bus_a.countdown, bus_a.request_pending, bus_a.fault);
      end
      step();
      checks++; if (bus_a.walk !== 1'b0 || bus_a.request_pending !== 1'b0) begin
         errors++; $display("FAIL rst_no_walk_after: got walk=%b req=%b expected 0/0", bus_a.walk, bus_a.request_pending);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus_a.enable = 1'b1;
      bus_a.red    = 1'b0;
      bus_a.yellow = 1'b0;
      bus_a.green  = 1'b1;
      bus_a.button = 1'b0;
      bus_b.enable = 1'b0;
      bus_b.red    = 1'b0;
      bus_b.yellow = 1'b0;
      bus_b.green  = 1'b1;
      bus_b.button = 1'b0;

      test_reset();
      test_nominal();
      test_mid_red();
      test_abort();
      test_illegal();
      test_enable_gating();
      test_reset_mid_flash();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ped_signal_ctrl.md
# ped_signal_ctrl

Pedestrian signal controller downstream of the vehicle traffic-light FSM. It consumes the light's one-hot `red`/`yellow`/`green` outputs and its `enable` tick. It latches pedestrian button requests and grants a WALK phase only at the start of a vehicle red phase, followed by a flashing DON'T WALK countdown. Any loss of vehicle red, or any malformed light encoding, during a pedestrian phase forces a safe abort.

## Interface
- `WALK_TICKS`, default 16: steady WALK duration in enable ticks; legal range 1..63.
- `FLASH_TICKS`, default 8: flashing DON'T WALK duration in enable ticks; legal range 1..63.
- `clk`  in  1  Single system clock; all logic is rising-edge.
- `reset`  in  1  Synchronous, active-high reset.
- `enable`  in  1  Time-base tick, the same signal that drives the light FSM. Counters advance only when it is high.
- `red`  in  1  Vehicle red from the light FSM.
- `yellow`  in  1  Vehicle yellow from the light FSM.
- `green`  in  1  Vehicle green from the light FSM.
- `button`  in  1  Pedestrian request, level-sensitive and already synchronous to `clk`.
- `walk`  out  1  WALK lamp.
- `dont_walk`  out  1  DON'T WALK lamp; steady or flashing.
- `countdown`  out  6  Remaining ticks in the current pedestrian phase; 0 when idle.
- `request_pending`  out  1  A request is latched and not yet served.
- `fault`  out  1  One-cycle pulse on a safety abort or a malformed light encoding.

## Operation
- **Reset values:** `walk`=0, `dont_walk`=1, `countdown`=0, `request_pending`=0, `fault`=0, state IDLE.
  - The internal delayed red, `red_q`, resets to 1. This prevents a spurious red edge on the first cycle after reset.
- **Red rising edge:** `red_rise` = `red` & ~`red_q`. `red_q` samples `red` every cycle, independent of `enable`.
- **Request latch:** `button`=1 on any cycle sets `request_pending`.
  - It is cleared on the cycle the block enters WALK.
  - If `button` is high on that same cycle, set wins: a held button requests the next cycle.
- **Encoding check:** the light is legal when exactly one of `red`/`yellow`/`green` is high. This is checked every cycle, regardless of `enable`.
- **States:**
  - **IDLE:** `walk`=0, `dont_walk`=1, `countdown`=0.
    - Go to WALK on `red_rise` & `request_pending` & legal encoding; load `countdown`=`WALK_TICKS`.
    - A request made while red is already on waits for the next red rising edge. There is no mid-red WALK.
  - **WALK:** `walk`=1, `dont_walk`=0.
    - On each `enable`, `countdown` decrements.
    - On `enable` with `countdown`==1, go to FLASH and load `countdown`=`FLASH_TICKS`.
  - **FLASH:** `walk`=0. `dont_walk` follows a phase bit that is 1 on FLASH entry and toggles on each `enable`.
    - On each `enable`, `countdown` decrements.
    - On `enable` with `countdown`==1, go to IDLE with `countdown`=0 and `dont_walk`=1 steady.
- **Abort:** in WALK or FLASH, `red`=0 or an illegal encoding causes the next state to be IDLE.
  - Outputs go to `walk`=0, `dont_walk`=1, `countdown`=0, `fault`=1 for one cycle.
  - `request_pending` is unchanged.
- **Fault in IDLE:** an illegal encoding in IDLE pulses `fault` for each cycle it persists. State stays IDLE, and no WALK entry is allowed that cycle.
- **Enable low:** counters and the flash phase hold. Edge detection, the request latch, abort and `fault` remain live.
- **Arithmetic:** `countdown` is 6-bit unsigned and never decrements below 1 within a phase, so it never wraps.
- **Precedence:** reset > abort/fault > phase transition > countdown decrement.

## Timing
- All outputs are registered and change only on a `clk` rising edge.
- Request latency: `button` high at cycle t gives `request_pending`=1 at t+1.
- WALK entry: `red_rise` at cycle t gives `walk`=1 and `countdown`=`WALK_TICKS` at t+1. `request_pending`=0 at t+1 unless `button` was high at t.
- WALK lasts exactly `WALK_TICKS` enable ticks after entry; the entry cycle's `enable` is not counted. The same rule applies to FLASH with `FLASH_TICKS`.
- Abort: the violating input at cycle t gives safe outputs and `fault`=1 at t+1, and `fault`=0 at t+2 unless the violation persists.
- Reset at any cycle, including mid-WALK: reset values at the next edge; the pending request is discarded.

## Test plan
- **Nominal request:** press `button` one cycle while green, then let the light cycle to red with `enable` every cycle.
  - `walk`=1 on the cycle after red rises, with `countdown`=16.
  - Exactly 16 ticks later, FLASH with `countdown`=8; `dont_walk` toggles 1,0,1,… over 8 ticks.
  - Then IDLE with `dont_walk`=1 and `countdown`=0.
- **Mid-red press:** press `button` while red is already high → no WALK in this red; WALK starts one cycle after the next red rising edge.
- **Red dropped mid-WALK:** force green high at WALK tick 5 → next cycle `walk`=0, `dont_walk`=1, `countdown`=0, `fault`=1 for exactly one cycle.
- **Illegal encoding:** drive `red`=`yellow`=1 for 3 cycles in IDLE → `fault`=1 for 3 cycles; `red_rise` coincident with an illegal encoding produces no WALK.
- **Enable gating:** `enable` asserted every 4th cycle with `WALK_TICKS`=2, `FLASH_TICKS`=1 → WALK lasts 2 enable ticks and FLASH 1 tick; `countdown` holds between ticks.
- **Reset mid-FLASH, red high afterwards:** reset during FLASH → all reset values; `request_pending`=0. No WALK on the first cycle after release even though `red`=1, because `red_q` resets to 1.
